// File: rtl/debounce_scheduler.sv
// ---------------------------------------------------------------------------
// debounce_scheduler
//
// Purpose:
//   Debounces N_INPUTS button/switch lines with one shared stability counter.
//   A round-robin scheduler hands the counter to one line with a pending
//   change at a time. The output is a set of stable levels plus a one-cycle
//   change pulse for each committed update.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   value_in     raw asynchronous button lines
//   value_out    debounced stable levels
//   changed      one-cycle pulse on the bit whose value_out just updated
//   busy         high while the shared counter is granted (COUNT or COMMIT)
//   active_ch    channel currently granted, 0 when idle
//   glitch_count saturating count of aborted COUNT phases (optional)
//
// Optional feature:
//   Define DEBOUNCE_GLITCH_CNT_EN to add the glitch_count output.
// ---------------------------------------------------------------------------
module debounce_scheduler #(
    parameter int   N_INPUTS   = 4,
    parameter int   CLK_FREQ   = 50,
    parameter int   TIME_DELAY = 1,
    parameter logic IDLE_LEVEL = 1'b1,
    localparam int  PTR_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] value_in,
    output logic [N_INPUTS-1:0] value_out,
    output logic [N_INPUTS-1:0] changed,
    output logic                busy,
    output logic [PTR_W-1:0]    active_ch
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0]          glitch_count
`endif
);

    localparam int MAX_CLK_COUNT = TIME_DELAY * CLK_FREQ * 1000;
    localparam int CNT_W         = $clog2(MAX_CLK_COUNT);

    typedef enum logic [1:0] {
        SCAN,
        COUNT,
        COMMIT
    } state_t;

    state_t               state, state_next;
    logic [N_INPUTS-1:0]  sync1, sync2;
    logic [N_INPUTS-1:0]  value_out_next;
    logic [N_INPUTS-1:0]  changed_next;
    logic [N_INPUTS-1:0]  pending;
    logic [PTR_W-1:0]     ptr, ptr_next;
    logic [PTR_W-1:0]     ch, ch_next;
    logic                 target, target_next;
    logic [CNT_W-1:0]     counter, counter_next;
    logic                 abort;
    logic                 found;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W-1:0]     idx;

    // Modulo-N increment; works for any N, not just powers of two, and
    // keeps the pointer pinned at 0 when there is only one line.
    function automatic logic [PTR_W-1:0] next_index(input logic [PTR_W-1:0] i);
        if (i == PTR_W'(N_INPUTS - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // A line needs service whenever its synchronized level disagrees with
    // the level we currently publish.
    assign pending = sync2 ^ value_out;

    // The counter is only "owned" outside SCAN; report the owner, or 0.
    assign busy      = (state != SCAN);
    assign active_ch = busy ? ch : '0;

    // Next-state logic. SCAN walks the pending bits starting at ptr so every
    // line gets a fair turn. COUNT restarts from scratch on any disagreement
    // with the latched target; a waiting line never carries partial credit.
    always_comb begin
        state_next     = state;
        ch_next        = ch;
        target_next    = target;
        counter_next   = counter;
        ptr_next       = ptr;
        value_out_next = value_out;
        changed_next   = '0;
        abort          = 1'b0;
        found          = 1'b0;
        grant_idx      = ptr;
        idx            = ptr;

        case (state)
            SCAN: begin
                for (int k = 0; k < N_INPUTS; k++) begin
                    if (!found && pending[idx]) begin
                        found     = 1'b1;
                        grant_idx = idx;
                    end
                    idx = next_index(idx);
                end
                if (found) begin
                    ch_next      = grant_idx;
                    target_next  = sync2[grant_idx];
                    counter_next = '0;
                    state_next   = COUNT;
                end
            end

            COUNT: begin
                if (sync2[ch] != target) begin
                    abort        = 1'b1;
                    counter_next = '0;
                    ptr_next     = next_index(ch);
                    state_next   = SCAN;
                end else if (counter == CNT_W'(MAX_CLK_COUNT - 1)) begin
                    state_next = COMMIT;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end

            COMMIT: begin
                value_out_next[ch] = target;
                changed_next[ch]   = 1'b1;
                ptr_next           = next_index(ch);
                state_next         = SCAN;
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

    // State and datapath registers, including the two-flop synchronizer.
    // Reset drops any committed pulse that has not yet been seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            sync1     <= {N_INPUTS{IDLE_LEVEL}};
            sync2     <= {N_INPUTS{IDLE_LEVEL}};
            value_out <= {N_INPUTS{IDLE_LEVEL}};
            changed   <= '0;
            ptr       <= '0;
            ch        <= '0;
            target    <= IDLE_LEVEL;
            counter   <= '0;
        end else begin
            state     <= state_next;
            sync1     <= value_in;
            sync2     <= sync1;
            value_out <= value_out_next;
            changed   <= changed_next;
            ptr       <= ptr_next;
            ch        <= ch_next;
            target    <= target_next;
            counter   <= counter_next;
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Every aborted COUNT is a bounce or glitch; count them, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_count <= '0;
        end else if (abort && (glitch_count != 8'hFF)) begin
            glitch_count <= glitch_count + 8'd1;
        end
    end
`else
    // Without the glitch counter the abort strobe has no consumer.
    logic unused_abort;
    assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_debounce_scheduler.sv
// ---------------------------------------------------------------------------
// tb_debounce_scheduler
//
// Directed bench for debounce_scheduler. The design is built with a 1 MHz /
// 1 ms configuration so the stable time is 1000 cycles; every expected edge
// below is written in terms of MAX.
// ---------------------------------------------------------------------------
module tb_debounce_scheduler;

    localparam int MAX = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] value_in = 4'hF;
    logic [3:0] value_out;
    logic [3:0] changed;
    logic       busy;
    logic [1:0] active_ch;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int mark     = 0;

    debounce_scheduler #(
        .N_INPUTS  (4),
        .CLK_FREQ  (1),
        .TIME_DELAY(1),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .value_out(value_out),
        .changed  (changed),
        .busy     (busy),
        .active_ch(active_ch)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count(glitch_count)
`endif
    );

    always #5 clk = ~clk;

    // Count every cycle that carries a change pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && changed != 4'h0) begin
            pulses++;
        end
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input int n);
        value_in = v;
        waitCycles(n);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic doReset();
        rst      = 1'b1;
        value_in = 4'hF;
        waitCycles(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        waitCycles(2);
        checkOutput("rst_value_out", 32'(value_out), 32'hF);
        checkOutput("rst_changed", 32'(changed), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_active_ch", 32'(active_ch), 32'h0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkOutput("rst_glitch_count", 32'(glitch_count), 32'h0);
`endif
        rst = 1'b0;

        // Clean press on ch1: commit on edge MAX+4
        $display("[TB] clean press on ch1");
        mark = pulses;
        applyStimulus(4'hD, 2);
        checkOutput("press_busy_sync", 32'(busy), 32'h0);
        waitCycles(1);
        checkOutput("press_busy_grant", 32'(busy), 32'h1);
        checkOutput("press_active_ch", 32'(active_ch), 32'h1);
        waitCycles(MAX);
        checkOutput("press_before_commit", 32'(value_out), 32'hF);
        checkOutput("press_changed_early", 32'(changed), 32'h0);
        waitCycles(1);
        checkOutput("press_value_out", 32'(value_out), 32'hD);
        checkOutput("press_changed", 32'(changed), 32'h2);
        checkOutput("press_busy_after", 32'(busy), 32'h0);
        waitCycles(1);
        checkOutput("press_changed_clear", 32'(changed), 32'h0);
        checkOutput("press_pulse_count", 32'(pulses - mark), 32'd1);

        // Round robin from ptr=2: ch0 and ch3 pending, ch3 wins
        $display("[TB] round robin from ptr 2");
        applyStimulus(4'b0100, 3);
        checkOutput("rr_first_ch", 32'(active_ch), 32'h3);
        waitCycles(MAX + 1);
        checkOutput("rr_first_commit", 32'(value_out), 32'h5);
        checkOutput("rr_first_changed", 32'(changed), 32'h8);
        waitCycles(MAX + 2);
        checkOutput("rr_second_commit", 32'(value_out), 32'h4);
        checkOutput("rr_second_changed", 32'(changed), 32'h1);

        // Glitches on ch0 never reach the output
        $display("[TB] glitches on ch0");
        doReset();
        mark = pulses;
        applyStimulus(4'hE, 10);
        applyStimulus(4'hF, 10);
        applyStimulus(4'hE, MAX / 2);
        applyStimulus(4'hF, 20);
        checkOutput("glitch_value_out", 32'(value_out), 32'hF);
        checkOutput("glitch_busy", 32'(busy), 32'h0);
        checkOutput("glitch_no_pulse", 32'(pulses - mark), 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkOutput("glitch_count", 32'(glitch_count), 32'd2);
`endif

        // Contention from ptr=0: ch0 first, ch3 MAX+2 cycles later
        $display("[TB] contention ch0/ch3");
        doReset();
        applyStimulus(4'b0110, 3);
        checkOutput("cont_busy", 32'(busy), 32'h1);
        checkOutput("cont_first_ch", 32'(active_ch), 32'h0);
        waitCycles(MAX + 1);
        checkOutput("cont_first_commit", 32'(value_out), 32'hE);
        checkOutput("cont_first_changed", 32'(changed), 32'h1);
        waitCycles(1);
        checkOutput("cont_second_ch", 32'(active_ch), 32'h3);
        waitCycles(MAX);
        checkOutput("cont_second_early", 32'(value_out), 32'hE);
        waitCycles(1);
        checkOutput("cont_second_commit", 32'(value_out), 32'h6);
        checkOutput("cont_second_changed", 32'(changed), 32'h8);
        // ptr wrapped to 0, so releasing both picks ch0 first again
        applyStimulus(4'hF, 3);
        checkOutput("cont_wrap_busy", 32'(busy), 32'h1);
        checkOutput("cont_wrap_ch", 32'(active_ch), 32'h0);
        waitCycles(2 * MAX + 10);
        checkOutput("cont_release_all", 32'(value_out), 32'hF);

        // A waiting line that returns to its old level is skipped
        $display("[TB] waiting line returns");
        doReset();
        mark = pulses;
        applyStimulus(4'b1100, 100);
        applyStimulus(4'b1110, MAX - 96);
        checkOutput("wait_commit", 32'(value_out), 32'hE);
        checkOutput("wait_changed", 32'(changed), 32'h1);
        waitCycles(4);
        checkOutput("wait_idle", 32'(busy), 32'h0);
        checkOutput("wait_value_out", 32'(value_out), 32'hE);
        checkOutput("wait_pulse_count", 32'(pulses - mark), 32'd1);

        // Reset in the middle of COUNT, then a full-latency commit
        $display("[TB] reset mid count");
        doReset();
        applyStimulus(4'hB, 3 + MAX / 2);
        checkOutput("midrst_busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("midrst_value_out", 32'(value_out), 32'hF);
        checkOutput("midrst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        waitCycles(MAX + 3);
        checkOutput("midrst_before_commit", 32'(value_out), 32'hF);
        waitCycles(1);
        checkOutput("midrst_commit", 32'(value_out), 32'hB);
        checkOutput("midrst_changed", 32'(changed), 32'h4);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // 300 aborts on ch1 saturate the glitch counter
        $display("[TB] glitch counter saturation");
        doReset();
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'hD, 6);
            applyStimulus(4'hF, 6);
        end
        checkOutput("sat_glitch_count", 32'(glitch_count), 32'd255);
        checkOutput("sat_value_out", 32'(value_out), 32'hF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N_INPUTS push-button/switch lines using a single shared debounce counter, not one counter per line.
- A round-robin scheduler grants the counter to one line at a time, whichever shows a pending change.
- Sits between the board button pins and the serial-bus master/slave control logic.
- Emits stable levels plus one-cycle change pulses.

Parameters:
- N_INPUTS, 4, number of raw input lines (2..16).
- CLK_FREQ, 50, clock frequency in MHz.
- TIME_DELAY, 1, required stable time in ms.
- IDLE_LEVEL, 1'b1, reset and idle level of every line (buttons are active-low).
- MAX_CLK_COUNT (localparam), TIME_DELAY*CLK_FREQ*1000, stable cycles required; default 50000.
- CNT_W (localparam), $clog2(MAX_CLK_COUNT), counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- value_in  input  N_INPUTS  raw asynchronous button lines.
- value_out  output  N_INPUTS  debounced stable levels.
- changed  output  N_INPUTS  one-cycle pulse on the bit whose value_out just updated.
- busy  output  1  high while the shared counter is granted (COUNT or COMMIT).
- active_ch  output  $clog2(N_INPUTS)  channel currently granted; 0 when idle.

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset values:
  - value_out = {N_INPUTS{IDLE_LEVEL}}.
  - changed = 0, busy = 0, active_ch = 0.
  - Synchronizer flops = IDLE_LEVEL.
  - Counter = 0, round-robin pointer ptr = 0, state = SCAN.
- Synchronizer: 2-flop per line; sync[i] is the second flop. Only sync[] is used downstream.
- pending[i] = sync[i] != value_out[i].
- SCAN:
  - If no bit of pending is set: stay in SCAN.
  - Otherwise grant the first pending index searching ptr, ptr+1, ... wrapping mod N_INPUTS.
  - On grant: latch ch, latch target = sync[ch], clear the counter, go to COUNT.
- COUNT:
  - If sync[ch] != target: abort. Counter = 0, ptr = ch+1 mod N, go to SCAN; value_out is unchanged.
  - Otherwise counter increments.
  - When counter == MAX_CLK_COUNT-1 (checked before the increment): go to COMMIT.
- COMMIT (one cycle): value_out[ch] <= target; changed[ch] <= 1; ptr = ch+1 mod N; go to SCAN.
- changed is registered and high for exactly one cycle, aligned with the new value_out.
- Latency, uncontended change: value_out updates on rising edge MAX_CLK_COUNT+4 counted from the first edge that samples the new level.
  - Edges 1-2: synchronizer.
  - Edge 3: grant.
  - Edges 4..MAX+3: count.
  - Edge MAX+4: commit.
- Simultaneous pending lines: serviced one at a time in round-robin order. A waiting line does not accumulate count; it is re-evaluated when granted. Worst-case wait before grant is (N_INPUTS-1)*(MAX_CLK_COUNT+2) cycles.
- Line returns to value_out level while waiting: its pending bit clears and it is skipped; no event.
- Glitch shorter than MAX_CLK_COUNT cycles: never reaches value_out.
- rst asserted in any state: next state is SCAN with all reset values, including mid-COUNT. A pending committed pulse is dropped.
- N_INPUTS==1: ptr stays 0.

Optional Feature:
- Macro: DEBOUNCE_GLITCH_CNT_EN.
- Defined:
  - Adds output glitch_count [7:0].
  - Increments on every COUNT abort and saturates at 255.
  - Reset to 0 by rst.
- Undefined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles, value_in=4'hF -> value_out=4'hF, changed=0, busy=0, active_ch=0.
- Clean press on ch1: value_in 4'hF->4'hD held -> value_out=4'hD exactly on edge 50004. changed=4'b0010 for that one cycle, active_ch=1 during COUNT.
- Glitch: ch0 low for 10 cycles, then high, then low for 25000 cycles, then high -> value_out stays 4'hF, no changed pulse. With DEBOUNCE_GLITCH_CNT_EN, glitch_count=2.
- Contention: ch3 and ch0 go low on the same cycle, ptr=0 -> ch0 commits first, then ch3 commits 50002 cycles later. ptr ends at 0 (3+1 mod 4).
- Reset mid-COUNT: ch2 low, assert rst at 25000 cycles into COUNT -> value_out=4'hF, busy=0. After release with ch2 still low, ch2 commits a full 50004 edges later.
- Saturation (macro on): 300 aborts on ch1 -> glitch_count=255.
